// File: rtl/load_return_buffer_pkg.sv
// rtl/load_return_buffer_pkg.sv - shared memory-interface types for load responses
//
// Holds the default load data / ldstID widths and the response entry struct
// used by the load/store queue, the DCache and the load return buffer.
package load_return_buffer_pkg;

    localparam int LRB_DATA_W = 32;
    localparam int LRB_ID_W   = 4;

    typedef struct packed {
        logic [LRB_DATA_W-1:0] data;
        logic [LRB_ID_W-1:0]   ldst_id;
    } mem_resp_t;

endpackage

// File: rtl/load_return_buffer.sv
// rtl/load_return_buffer.sv - FIFO of DCache load responses awaiting core writeback
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   valid_in_M          DCache response valid
//   data_in_M           DCache response data
//   ldstID_in_M         ldstID of the response
//   stall_out_M         buffer full, DCache must hold responses
//   valid_out_C         head response available to writeback
//   data_out_C          head data (zero when not valid)
//   ldstID_out_C        head ldstID (zero when not valid)
//   ready_in_C          core accepts the head this cycle
//   count_out           occupancy
//   overflow_out        sticky: a response was dropped while full
//
// Build option: LOAD_RETURN_BUFFER_BYPASS_EN - when the buffer is empty the
// incoming response is presented directly on the C outputs and, if accepted,
// never written into the buffer.
module load_return_buffer
    import load_return_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = LRB_DATA_W,
    parameter int ID_W   = LRB_ID_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in_M,
    input  logic [DATA_W-1:0]        data_in_M,
    input  logic [ID_W-1:0]          ldstID_in_M,
    output logic                     stall_out_M,
    output logic                     valid_out_C,
    output logic [DATA_W-1:0]        data_out_C,
    output logic [ID_W-1:0]          ldstID_out_C,
    input  logic                     ready_in_C,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mem_resp_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    logic               empty;
    logic               full;
    logic               bypass;
    logic               take_bypass;
    logic               do_push;
    logic               do_pop;
    logic               do_drop;
    mem_resp_t          head;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr];

`ifdef LOAD_RETURN_BUFFER_BYPASS_EN
    assign bypass = empty && valid_in_M;
`else
    assign bypass = 1'b0;
`endif

    // Handshakes are qualified by rst so a reset cycle neither pushes nor pops.
    assign do_pop      = rst && !empty && ready_in_C;
    assign take_bypass = rst && bypass && ready_in_C;
    assign do_push     = rst && valid_in_M && !take_bypass && (!full || do_pop);
    assign do_drop     = rst && valid_in_M && full && !do_pop;

    // Outputs are forced quiet while reset is asserted, not just after it.
    always_comb begin
        valid_out_C  = 1'b0;
        data_out_C   = '0;
        ldstID_out_C = '0;
        if (rst && !empty) begin
            valid_out_C  = 1'b1;
            data_out_C   = DATA_W'(head.data);
            ldstID_out_C = ID_W'(head.ldst_id);
        end else if (rst && bypass) begin
            valid_out_C  = 1'b1;
            data_out_C   = data_in_M;
            ldstID_out_C = ldstID_in_M;
        end
    end

    assign stall_out_M  = rst && full;
    assign count_out    = rst ? count : '0;
    assign overflow_out = overflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{data: LRB_DATA_W'(data_in_M), ldst_id: LRB_ID_W'(ldstID_in_M)};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (do_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_return_buffer.sv
// tb/tb_load_return_buffer.sv - directed vector bench for load_return_buffer
module tb_load_return_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_M;
    logic [31:0] data_in_M;
    logic [3:0]  ldstID_in_M;
    logic        stall_out_M;
    logic        valid_out_C;
    logic [31:0] data_out_C;
    logic [3:0]  ldstID_out_C;
    logic        ready_in_C;
    logic [2:0]  count_out;
    logic        overflow_out;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    load_return_buffer #(.DEPTH(4), .DATA_W(32), .ID_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in_M   (valid_in_M),
        .data_in_M    (data_in_M),
        .ldstID_in_M  (ldstID_in_M),
        .stall_out_M  (stall_out_M),
        .valid_out_C  (valid_out_C),
        .data_out_C   (data_out_C),
        .ldstID_out_C (ldstID_out_C),
        .ready_in_C   (ready_in_C),
        .count_out    (count_out),
        .overflow_out (overflow_out)
    );

    typedef struct {
        logic        rst;
        logic        vin;
        logic [31:0] din;
        logic [3:0]  idin;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  eid;
        logic [2:0]  ec;
        logic        es;
        logic        eo;
    } vec_t;

    vec_t vt [27];

    function automatic vec_t mk(logic r, logic vi, int di, int ii, logic rd,
                                logic ev, int ed, int eid, int ec, logic es, logic eo);
        vec_t v;
        v.rst = r; v.vin = vi; v.din = 32'(di); v.idin = 4'(ii); v.rdy = rd;
        v.ev = ev; v.ed = 32'(ed); v.eid = 4'(eid); v.ec = 3'(ec); v.es = es; v.eo = eo;
        return v;
    endfunction

    task automatic check_all(string name, logic ev, logic [31:0] ed, logic [3:0] eid,
                             logic [2:0] ec, logic es, logic eo);
        n_vec++;
        if (valid_out_C !== ev || data_out_C !== ed || ldstID_out_C !== eid ||
            count_out !== ec || stall_out_M !== es || overflow_out !== eo) begin
            n_miss++;
            $display("FAIL %s: got v=%0b d=%h id=%0d c=%0d s=%0b o=%0b want v=%0b d=%h id=%0d c=%0d s=%0b o=%0b",
                     name, valid_out_C, data_out_C, ldstID_out_C, count_out, stall_out_M, overflow_out,
                     ev, ed, eid, ec, es, eo);
        end
    endtask

    task automatic check_val(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(logic r, logic vi, logic [31:0] di, logic [3:0] ii, logic rd);
        @(negedge clk);
        rst = r; valid_in_M = vi; data_in_M = di; ldstID_in_M = ii; ready_in_C = rd;
        #1;
    endtask

    initial begin
        rst = 1'b0; valid_in_M = 1'b0; data_in_M = '0; ldstID_in_M = '0; ready_in_C = 1'b0;

        //               rst vin din   id rdy  ev  ed   eid ec es eo
        vt[0]  = mk(1, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0);
        vt[1]  = mk(1, 1, 101, 1, 0,   0, 0,   0, 0, 0, 0);
        vt[2]  = mk(1, 1, 102, 2, 0,   1, 101, 1, 1, 0, 0);
        vt[3]  = mk(1, 1, 103, 3, 0,   1, 101, 1, 2, 0, 0);
        vt[4]  = mk(1, 1, 104, 4, 0,   1, 101, 1, 3, 0, 0);
        vt[5]  = mk(1, 1, 105, 5, 0,   1, 101, 1, 4, 1, 0);
        vt[6]  = mk(1, 0, 0,   0, 0,   1, 101, 1, 4, 1, 1);
        vt[7]  = mk(0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 1);
        vt[8]  = mk(1, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0);
        vt[9]  = mk(1, 1, 201, 1, 0,   0, 0,   0, 0, 0, 0);
        vt[10] = mk(1, 1, 202, 2, 0,   1, 201, 1, 1, 0, 0);
        vt[11] = mk(1, 1, 203, 3, 0,   1, 201, 1, 2, 0, 0);
        vt[12] = mk(1, 1, 204, 4, 0,   1, 201, 1, 3, 0, 0);
        vt[13] = mk(1, 1, 207, 7, 1,   1, 201, 1, 4, 1, 0);
        vt[14] = mk(1, 0, 0,   0, 1,   1, 202, 2, 4, 1, 0);
        vt[15] = mk(1, 0, 0,   0, 1,   1, 203, 3, 3, 0, 0);
        vt[16] = mk(1, 0, 0,   0, 1,   1, 204, 4, 2, 0, 0);
        vt[17] = mk(1, 0, 0,   0, 1,   1, 207, 7, 1, 0, 0);
        vt[18] = mk(1, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0);
        vt[19] = mk(1, 1, 301, 1, 0,   0, 0,   0, 0, 0, 0);
        vt[20] = mk(1, 1, 302, 2, 0,   1, 301, 1, 1, 0, 0);
        vt[21] = mk(1, 1, 303, 3, 0,   1, 301, 1, 2, 0, 0);
        vt[22] = mk(0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0);
        vt[23] = mk(1, 1, 400, 5, 0,   0, 0,   0, 0, 0, 0);
        vt[24] = mk(1, 0, 0,   0, 1,   1, 400, 5, 1, 0, 0);
        vt[25] = mk(1, 0, 0,   0, 1,   0, 0,   0, 0, 0, 0);
        vt[26] = mk(1, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0);

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            vec_t v;
            v = vt[i];
`ifdef LOAD_RETURN_BUFFER_BYPASS_EN
            // An empty buffer shows the incoming response directly.
            if (v.rst && v.vin && v.ec == 0) begin
                v.ev = 1'b1; v.ed = v.din; v.eid = v.idin;
            end
`endif
            drive(v.rst, v.vin, v.din, v.idin, v.rdy);
            check_all($sformatf("vec%0d", i), v.ev, v.ed, v.eid, v.ec, v.es, v.eo);
        end

        // Two responses with the core always ready: delivered in order.
        begin
            int got_n = 0;
            logic [31:0] dd [2] = '{32'd9000, 32'd9001};
            logic [3:0]  ii [2] = '{4'd1, 4'd2};
            for (int c = 0; c < 5; c++) begin
                if (c < 2) drive(1, 1, dd[c], ii[c], 1);
                else       drive(1, 0, 0, 0, 1);
                if (valid_out_C && got_n < 2) begin
                    check_val($sformatf("inorder_id%0d", got_n), int'(ldstID_out_C), int'(ii[got_n]));
                    check_val($sformatf("inorder_d%0d", got_n), int'(data_out_C), int'(dd[got_n]));
                    got_n++;
                end
            end
            check_val("inorder_count", got_n, 2);
            check_val("inorder_occ", int'(count_out), 0);
        end

        // Push into an empty buffer with the core ready.
        drive(1, 1, 32'hDEAD, 4'd3, 1);
`ifdef LOAD_RETURN_BUFFER_BYPASS_EN
        check_all("empty_push_now", 1, 32'hDEAD, 3, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        check_all("empty_push_next", 0, 0, 0, 0, 0, 0);
`else
        check_all("empty_push_now", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        check_all("empty_push_next", 1, 32'hDEAD, 3, 1, 0, 0);
`endif
        drive(1, 0, 0, 0, 0);
        check_all("empty_push_done", 0, 0, 0, 0, 0, 0);

        // Wrap-around: pushes on two of three cycles, pops on alternate cycles.
        begin
            int sent = 0;
            int got_n = 0;
            for (int c = 0; c < 80 && got_n < 10; c++) begin
                logic vi;
                logic rd;
                @(negedge clk);
                vi = (sent < 10) && (c % 3 != 2) && !stall_out_M;
                rd = (c % 2) == 1;
                rst = 1'b1; valid_in_M = vi; data_in_M = 32'(500 + sent);
                ldstID_in_M = 4'(sent); ready_in_C = rd;
                #1;
                if (valid_out_C && rd) begin
                    check_val($sformatf("wrap_id%0d", got_n), int'(ldstID_out_C), got_n);
                    check_val($sformatf("wrap_d%0d", got_n), int'(data_out_C), 500 + got_n);
                    got_n++;
                end
                if (vi) sent++;
            end
            check_val("wrap_delivered", got_n, 10);
            drive(1, 0, 0, 0, 0);
            check_all("wrap_end", 0, 0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
